lm75a_i2c_reader: RTL and testbench
===================================

# lm75a_i2c_reader

I2C master that periodically reads the 16-bit temperature register of an LM75A sensor and presents it as a held parallel word. It produces the `data[15:0]` bus consumed by the 7-segment temperature display driver: MSB byte in `[15:8]`, LSB byte in `[7:0]`. It sits between the board's open-drain SCL/SDA pads and the display block.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency.
- `SCL_HZ`, 100_000, SCL frequency. `Q = CLK_HZ/(4*SCL_HZ)` clocks per quarter-bit; `Q` must be at least 2.
- `DEV_ADDR`, 7'h48, LM75A 7-bit slave address (A2..A0 = 0).
- `POLL_CYC`, 12_500_000, clocks between automatic read starts (250 ms at 50 MHz).

Ports:
- `clk`, in, 1, system clock. Single clock; all logic is on its rising edge.
- `rst_n`, in, 1, synchronous reset, active-low.
- `trig`, in, 1, one-cycle request for an immediate read.
- `scl_oe`, out, 1, 1 = pull SCL low, 0 = release. The pad is open-drain.
- `sda_oe`, out, 1, 1 = pull SDA low, 0 = release.
- `sda_i`, in, 1, synchronized SDA pad level.
- `data`, out, 16, last successfully read temperature word.
- `data_valid`, out, 1, one-cycle pulse when `data` updates.
- `ack_err`, out, 1, sticky flag set on address NACK. Cleared by the next successful read.
- `busy`, out, 1, high from the cycle after START begins through the end of STOP.

## Operation
- Reset values: `data = 16'h0000`, `data_valid = 0`, `ack_err = 0`, `busy = 0`, `scl_oe = 0`, `sda_oe = 0`. The poll counter is 0 and the FSM is in IDLE.
- The poll counter counts `0..POLL_CYC-1` and wraps. A wrap raises an internal start request. `trig` raises the same request.
- A request is taken only in IDLE. Requests during `busy` are dropped, not queued.
- The pointer register is not written. The LM75A power-on pointer is 0 (Temp), so each read is a bare read.
- Transaction: START, address byte `{DEV_ADDR,1'b1}` MSB first, slave ACK, MSB byte, master ACK (SDA low), LSB byte, master NACK (SDA released), STOP.
- FSM states: IDLE, START, ADDR, ADDR_ACK, RD_MSB, M_ACK, RD_LSB, M_NACK, STOP.
  - IDLE -> START on request.
  - START -> ADDR, then ADDR (8 bits) -> ADDR_ACK.
  - ADDR_ACK -> RD_MSB if sampled SDA = 0. Otherwise set `ack_err` and go to STOP.
  - RD_MSB (8 bits) -> M_ACK -> RD_LSB (8 bits) -> M_NACK -> STOP -> IDLE.
- Bit counter is 3 bits, counting 7 down to 0. The state advances on the 0 -> 7 wrap.
- Received bytes shift into a 16-bit shift register MSB first.
- On STOP completion after a good read: `data` is loaded from the shift register, `data_valid` pulses, `ack_err` clears.
- After an aborted (NACK) transaction, `data` holds its previous value and there is no `data_valid` pulse.
- Data is passed through verbatim. Bits `[4:0]` are not masked and sign bit 15 is not interpreted; the downstream block handles both.
- No clock stretching, no arbitration. SCL is never sampled.

## Timing
- Quarter tick: a counter `0..Q-1` that runs only outside IDLE. A 2-bit phase `p` advances on each tick.
- Data bit, `p0..p3`:
  - p0: SCL low; set `sda_oe`.
  - p1: SCL low.
  - p2: SCL released.
  - p3: SCL released.
  - `sda_i` is sampled on the last clock of p2.
- START:
  - p0–p1: SDA released, SCL released.
  - p2: SDA low.
  - p3: SCL low.
- STOP:
  - p0: SDA low, SCL low.
  - p1: SCL released.
  - p2: SDA released.
  - p3: idle.
- Total length: 1 + 9 + 9 + 9 + 1 = 29 bit times = 116·Q clocks (14_500 clocks at defaults). A NACK abort is 11 bit times.
- `data` and `data_valid` update one clock after the final STOP quarter. `busy` falls on the same edge.
- Request accepted in IDLE at cycle n -> `busy` = 1 at n+1, and START p0 begins at n+1.
- Poll wrap and `trig` in the same cycle produce a single transaction.
- `rst_n` low mid-transaction: on the next edge the outputs take their reset values. Both lines are released and no STOP is sent. The LM75A recovers at the next START.

## Structure
- Package `lm75a_pkg` holds:
  - the FSM state enum;
  - `LM75A_ADDR_DEFAULT = 7'h48`;
  - the `Q` derivation function;
  - the transaction length constant, 116 quarters.
- One sub-module, `i2c_qtick_gen`: quarter-period divider plus 2-bit phase counter, with `en` and `rst_n` inputs and `tick`/`phase` outputs.
- The FSM, shift register and poll counter stay in the top level.

## Test plan
- Slave model at 0x48 returns 8'h19 then 8'h80, `trig` pulsed -> `data = 16'h1980` and a one-cycle `data_valid` exactly 116·Q + 1 clocks after `trig`. SDA is low during M_ACK and released during M_NACK.
- No slave present (address NACK) after a good read of 16'h1980 -> `ack_err = 1`, `data` stays 16'h1980, no `data_valid`, STOP observed, transaction length 44·Q.
- `POLL_CYC = 20_000`, slave returns 8'h7D, 8'h00 -> back-to-back reads with starts exactly 20_000 clocks apart, `data = 16'h7D00` each time.
- `trig` held high for 3 cycles, then pulsed again mid-transaction -> exactly one transaction; later requests are ignored while `busy`.
- `rst_n` asserted during RD_MSB -> next edge `scl_oe = sda_oe = 0`, `busy = 0`, `data = 0`. After release, a `trig` yields a correct read.
- Protocol checker on the pins throughout: SDA changes only while SCL is low, except the START and STOP edges.

Source files
------------

// File: rtl/lm75a_pkg.sv
// lm75a_pkg: shared FSM states, default address and timing helpers for the LM75A reader.
package lm75a_pkg;
    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, RD_MSB, M_ACK, RD_LSB, M_NACK, STOP
    } state_e;

    localparam logic [6:0] LM75A_ADDR_DEFAULT = 7'h48;
    localparam int TXN_QUARTERS = 116;

    function automatic int calc_q(input int clk_hz, input int scl_hz);
        return clk_hz / (4 * scl_hz);
    endfunction
endpackage

// File: rtl/i2c_qtick_gen.sv
// i2c_qtick_gen: quarter-bit divider with a 2-bit phase counter; held at zero while disabled.
module i2c_qtick_gen #(
    parameter int Q = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       tick,
    output logic [1:0] phase
);
    localparam int CW = $clog2(Q);

    logic [CW-1:0] cnt_q;
    logic [1:0]    phase_q;

    assign tick  = en && cnt_q == CW'(Q - 1);
    assign phase = phase_q;

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt_q   <= '0;
            phase_q <= '0;
        end else begin
            cnt_q   <= tick ? '0 : cnt_q + 1'b1;
            phase_q <= phase_q + {1'b0, tick};
        end
    end
endmodule

// File: rtl/lm75a_i2c_reader.sv
// lm75a_i2c_reader: periodic/triggered I2C bare read of the LM75A temperature register.
module lm75a_i2c_reader
    import lm75a_pkg::*;
#(
    parameter int         CLK_HZ   = 50_000_000,
    parameter int         SCL_HZ   = 100_000,
    parameter logic [6:0] DEV_ADDR = LM75A_ADDR_DEFAULT,
    parameter int         POLL_CYC = 12_500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trig,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        sda_i,
    output logic [15:0] data,
    output logic        data_valid,
    output logic        ack_err,
    output logic        busy
);
    localparam int         Q         = calc_q(CLK_HZ, SCL_HZ);
    localparam int         PW        = $clog2(POLL_CYC);
    localparam logic [7:0] ADDR_BYTE = {DEV_ADDR, 1'b1};

    state_e        state_q, state_d;
    logic [PW-1:0] poll_q;
    logic [2:0]    bit_q;
    logic [15:0]   sh_q, data_q;
    logic          dv_q, err_q, ok_q;
    logic          tick, req, smp, bit_end;
    logic [1:0]    ph;

    i2c_qtick_gen #(.Q(Q)) u_qtick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q != IDLE),
        .tick  (tick),
        .phase (ph)
    );

    assign req        = trig || poll_q == PW'(POLL_CYC - 1);
    assign bit_end    = tick && ph == 2'd3;
    assign smp        = tick && ph == 2'd2 && (state_q inside {ADDR_ACK, RD_MSB, RD_LSB});
    assign busy       = state_q != IDLE;
    assign data       = data_q;
    assign data_valid = dv_q;
    assign ack_err    = err_q;

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE)
            state_d = req ? START : IDLE;
        else if (bit_end)
            case (state_q)
                START:    state_d = ADDR;
                ADDR:     state_d = bit_q == 3'd0 ? ADDR_ACK : ADDR;
                ADDR_ACK: state_d = sh_q[0] ? STOP : RD_MSB;
                RD_MSB:   state_d = bit_q == 3'd0 ? M_ACK : RD_MSB;
                M_ACK:    state_d = RD_LSB;
                RD_LSB:   state_d = bit_q == 3'd0 ? M_NACK : RD_LSB;
                M_NACK:   state_d = STOP;
                default:  state_d = IDLE;
            endcase
    end

    // Data bits hold SDA for the whole bit; SCL is low in p0-p1 and released in p2-p3.
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state_q)
            IDLE: ;
            START: begin
                sda_oe = ph[1];
                scl_oe = ph == 2'd3;
            end
            STOP: begin
                sda_oe = !ph[1];
                scl_oe = ph == 2'd0;
            end
            default: begin
                scl_oe = !ph[1];
                sda_oe = state_q == ADDR ? !ADDR_BYTE[bit_q] : state_q == M_ACK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            poll_q  <= '0;
            bit_q   <= 3'd7;
            sh_q    <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            poll_q  <= poll_q == PW'(POLL_CYC - 1) ? '0 : poll_q + 1'b1;
            dv_q    <= 1'b0;
            if (bit_end && (state_q inside {ADDR, RD_MSB, RD_LSB}))
                bit_q <= bit_q - 1'b1;
            if (smp)
                sh_q <= {sh_q[14:0], sda_i};
            // sh_q[0] holds the sampled slave ACK at the end of ADDR_ACK
            if (bit_end && state_q == ADDR_ACK) begin
                ok_q  <= !sh_q[0];
                err_q <= err_q | sh_q[0];
            end
            if (bit_end && state_q == STOP && ok_q) begin
                data_q <= sh_q;
                dv_q   <= 1'b1;
                err_q  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_lm75a_i2c_reader.sv
// tb_lm75a_i2c_reader: vector table, random reads against a pin-level slave model, and timing corner cases.
module tb_lm75a_i2c_reader;
    import lm75a_pkg::*;

    localparam int CLK_HZ = 1_600_000;
    localparam int SCL_HZ = 100_000;
    localparam int POLL   = 20_000;
    localparam int Q      = CLK_HZ / (4 * SCL_HZ);
    localparam int GOOD   = 116 * Q;
    localparam int BAD    = 44 * Q;
    localparam int LIMIT  = 2 * TXN_QUARTERS * Q + 10;

    logic        clk = 1'b0, rst_n = 1'b0, trig = 1'b0;
    logic        scl_oe, sda_oe, data_valid, ack_err, busy;
    logic [15:0] data;
    logic        scl_w, sda_w;

    logic [7:0]  s_msb = 8'h00, s_lsb = 8'h00;
    bit          s_present = 1'b0;
    logic        pull = 1'b0;
    logic [7:0]  s_addr = 8'h00;
    logic        s_mack = 1'b1, s_mnack = 1'b0;
    int          bitn = 0, n_start = 0, n_stop = 0, n_txn = 0;
    logic        scl_p = 1'b1, sda_p = 1'b1, busy_p = 1'b0;

    int          n_chk = 0, n_pass = 0;
    logic [15:0] exp_data = 16'h0000;
    logic        exp_err = 1'b0;

    typedef struct {
        logic [7:0]  m;
        logic [7:0]  l;
        bit          present;
        logic [15:0] e_data;
        logic        e_err;
    } vec_t;

    always #5 clk = ~clk;

    assign scl_w = ~scl_oe;
    assign sda_w = ~(sda_oe | pull);

    lm75a_i2c_reader #(
        .CLK_HZ(CLK_HZ), .SCL_HZ(SCL_HZ), .DEV_ADDR(7'h48), .POLL_CYC(POLL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trig(trig), .scl_oe(scl_oe), .sda_oe(sda_oe),
        .sda_i(sda_w), .data(data), .data_valid(data_valid), .ack_err(ack_err), .busy(busy)
    );

    // Slave bit for the bit following rising edge number b (bits numbered from 1 after START).
    function automatic logic drive(input int b);
        if (!s_present || s_addr != 8'h91) return 1'b0;
        if (b == 8) return 1'b1;
        if (b >= 9 && b <= 16) return !s_msb[16-b];
        if (b >= 18 && b <= 25) return !s_lsb[25-b];
        return 1'b0;
    endfunction

    // LM75A model plus START/STOP detection on the resolved pins.
    always @(negedge clk) begin
        busy_p <= busy;
        scl_p  <= scl_w;
        sda_p  <= sda_w;
        if (busy && !busy_p) n_txn <= n_txn + 1;
        if (!rst_n) begin
            bitn <= 0;
            pull <= 1'b0;
        end else if (scl_w && scl_p && sda_w != sda_p) begin
            if (!sda_w) n_start <= n_start + 1;
            else n_stop <= n_stop + 1;
            bitn <= 0;
            pull <= 1'b0;
        end else if (scl_w && !scl_p) begin
            bitn <= bitn + 1;
            if (bitn < 8) s_addr <= {s_addr[6:0], sda_w};
            if (bitn == 17) s_mack <= sda_w;
            if (bitn == 26) s_mnack <= sda_w;
        end else if (!scl_w && scl_p) begin
            pull <= drive(bitn);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic run_read(input string tag, input logic [7:0] m, input logic [7:0] l,
                            input bit present, input logic [15:0] e_data, input logic e_err);
        int t, st0, sp0;
        s_msb = m; s_lsb = l; s_present = present;
        st0 = n_start; sp0 = n_stop;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        t = 1;
        chk({tag, " busy_start"}, busy, 1);
        while (busy && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " length"}, t, present ? GOOD + 1 : BAD + 1);
        chk({tag, " data_valid"}, data_valid, present);
        chk({tag, " data"}, data, e_data);
        chk({tag, " ack_err"}, ack_err, e_err);
        chk({tag, " starts"}, n_start - st0, 1);
        chk({tag, " stops"}, n_stop - sp0, 1);
        if (present) begin
            chk({tag, " addr_byte"}, s_addr, 8'h91);
            chk({tag, " master_ack"}, s_mack, 0);
            chk({tag, " master_nack"}, s_mnack, 1);
        end
        @(negedge clk);
        chk({tag, " dv_one_cycle"}, data_valid, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        vec_t vecs[8];
        int t, tx0;
        logic [7:0] m, l;
        bit p;
        vecs = '{
            '{8'h19, 8'h80, 1'b1, 16'h1980, 1'b0},
            '{8'h00, 8'h00, 1'b0, 16'h1980, 1'b1},
            '{8'hAA, 8'h55, 1'b0, 16'h1980, 1'b1},
            '{8'h00, 8'h00, 1'b1, 16'h0000, 1'b0},
            '{8'hFF, 8'hFF, 1'b1, 16'hFFFF, 1'b0},
            '{8'hE7, 8'h00, 1'b1, 16'hE700, 1'b0},
            '{8'h7D, 8'h00, 1'b0, 16'hE700, 1'b1},
            '{8'h00, 8'h1F, 1'b1, 16'h001F, 1'b0}
        };

        repeat (3) @(negedge clk);
        chk("rst scl_oe", scl_oe, 0);
        chk("rst sda_oe", sda_oe, 0);
        chk("rst busy", busy, 0);
        chk("rst data", data, 0);
        chk("rst data_valid", data_valid, 0);
        chk("rst ack_err", ack_err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_read($sformatf("vec%0d", i), vecs[i].m, vecs[i].l, vecs[i].present,
                     vecs[i].e_data, vecs[i].e_err);
            exp_data = vecs[i].e_data;
            exp_err  = vecs[i].e_err;
        end

        for (int i = 0; i < 10; i++) begin
            m = 8'($urandom);
            l = 8'($urandom);
            p = $urandom_range(0, 3) != 0;
            if (p) begin
                exp_data = {m, l};
                exp_err  = 1'b0;
            end else begin
                exp_err = 1'b1;
            end
            run_read($sformatf("rnd%0d", i), m, l, p, exp_data, exp_err);
        end

        // trig held for 3 cycles, then pulsed again mid-transaction
        s_msb = 8'h12; s_lsb = 8'h34; s_present = 1'b1;
        tx0 = n_txn;
        trig = 1'b1;
        repeat (3) @(negedge clk);
        trig = 1'b0;
        repeat (100) @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        t = 0;
        while (busy && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        repeat (20) @(negedge clk);
        chk("hold busy_after", busy, 0);
        chk("hold txn_count", n_txn - tx0, 1);
        chk("hold data", data, 16'h1234);

        // reset asserted while the MSB byte is being read
        s_msb = 8'h19; s_lsb = 8'h80;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        repeat (50 * Q) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst scl_oe", scl_oe, 0);
        chk("midrst sda_oe", sda_oe, 0);
        chk("midrst busy", busy, 0);
        chk("midrst data", data, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        run_read("after_rst", 8'h19, 8'h80, 1'b1, 16'h1980, 1'b0);

        // automatic polling from a fresh reset
        s_msb = 8'h7D; s_lsb = 8'h00;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        while (!busy && t < POLL + 100) begin
            @(negedge clk);
            t++;
        end
        chk("poll first_start", t, POLL);
        for (int k = 0; k < 2; k++) begin
            t = 0;
            while (busy && t < LIMIT) begin
                @(negedge clk);
                t++;
            end
            chk($sformatf("poll%0d length", k), t, GOOD);
            chk($sformatf("poll%0d data_valid", k), data_valid, 1);
            chk($sformatf("poll%0d data", k), data, 16'h7D00);
            if (k == 0) begin
                while (!busy && t < POLL + 100) begin
                    @(negedge clk);
                    t++;
                end
                chk("poll period", t, POLL);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
